// File: rtl/edge_interval_meter.sv
// Counts edge-detector pulses and measures the CLK-cycle interval between
// successive pulses, presenting each result through a one-entry valid/ready register.
module edge_interval_meter #(
  parameter int CNT_W = 16,
  parameter int EVT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EDGE_PULSE,
  input  logic             CLR,
  input  logic             INT_READY,
  output logic [CNT_W-1:0] INTERVAL,
  output logic             INT_VALID,
  output logic [EVT_W-1:0] EVT_CNT,
  output logic             OVF,
  output logic             DROP
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMER_MAX = '1;
  localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0] interval_reg, interval_next;
  logic             valid_reg, valid_next;
  logic [EVT_W-1:0] evt_reg, evt_next;
  logic             ovf_reg, ovf_next;
  logic             drop_reg, drop_next;
  logic             capture;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: any accepted pulse leaves or keeps MEASURE; CLR always re-arms
  always_comb begin
    state_next = state_reg;
    if (CLR) begin
      state_next = IDLE;
    end else if (EDGE_PULSE) begin
      state_next = MEASURE;
    end
  end

  // Measurement datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_reg    <= '0;
      interval_reg <= '0;
      valid_reg    <= 1'b0;
      evt_reg      <= '0;
      ovf_reg      <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      timer_reg    <= timer_next;
      interval_reg <= interval_next;
      valid_reg    <= valid_next;
      evt_reg      <= evt_next;
      ovf_reg      <= ovf_next;
      drop_reg     <= drop_next;
    end
  end

  always_comb begin
    timer_next    = timer_reg;
    interval_next = interval_reg;
    valid_next    = valid_reg;
    evt_next      = evt_reg;
    ovf_next      = ovf_reg;
    drop_next     = 1'b0;
    capture       = 1'b0;

    if (CLR) begin
      // Interval data is deliberately kept; only its valid flag drops
      timer_next = '0;
      evt_next   = '0;
      ovf_next   = 1'b0;
      valid_next = 1'b0;
    end else begin
      if (EDGE_PULSE) begin
        evt_next = evt_reg + EVT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          timer_next = EDGE_PULSE ? TIMER_ONE : '0;
        end
        MEASURE: begin
          if (EDGE_PULSE) begin
            capture    = 1'b1;
            timer_next = TIMER_ONE;
          end else if (timer_reg == TIMER_MAX) begin
            ovf_next = 1'b1;
          end else begin
            timer_next = timer_reg + CNT_W'(1);
          end
        end
        default: timer_next = '0;
      endcase

      // A capture may overwrite the held result only if it is being consumed this cycle
      if (capture) begin
        if (!valid_reg || INT_READY) begin
          interval_next = timer_reg;
          valid_next    = 1'b1;
        end else begin
          drop_next = 1'b1;
        end
      end else if (valid_reg && INT_READY) begin
        valid_next = 1'b0;
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    INTERVAL  = interval_reg;
    INT_VALID = valid_reg;
    EVT_CNT   = evt_reg;
    OVF       = ovf_reg;
    DROP      = drop_reg;
  end

endmodule

// File: tb/tb_edge_interval_meter.sv
// Self-checking bench for edge_interval_meter: directed vector table, hand sequences
// for multi-cycle corners, and randomized traffic against a timestamp-based model.
module tb_edge_interval_meter;

  localparam int CNT_W = 4;
  localparam int EVT_W = 8;
  localparam int T_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EDGE_PULSE = 1'b0;
  logic             CLR = 1'b0;
  logic             INT_READY = 1'b0;
  logic [CNT_W-1:0] INTERVAL;
  logic             INT_VALID;
  logic [EVT_W-1:0] EVT_CNT;
  logic             OVF;
  logic             DROP;

  int checks = 0;
  int errors = 0;

  // Reference model: remembers the time of the last accepted event
  longint m_cyc;
  longint m_last;
  bit     m_armed;
  int     m_evt;
  int     m_interval;
  bit     m_valid;
  bit     m_ovf;
  bit     m_drop;

  typedef struct {
    logic p;
    logic c;
    logic r;
    int   e_interval;
    bit   e_valid;
    int   e_evt;
    bit   e_drop;
    bit   e_ovf;
  } vec_t;

  vec_t vecs [18];

  edge_interval_meter #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EDGE_PULSE(EDGE_PULSE),
    .CLR       (CLR),
    .INT_READY (INT_READY),
    .INTERVAL  (INTERVAL),
    .INT_VALID (INT_VALID),
    .EVT_CNT   (EVT_CNT),
    .OVF       (OVF),
    .DROP      (DROP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_last = 0; m_armed = 0; m_evt = 0;
    m_interval = 0; m_valid = 0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic model_edge(input logic p, input logic c, input logic r);
    bit cap_ok;
    int cap;
    m_cyc++;
    m_drop = 0;
    cap_ok = 0;
    cap = 0;
    if (c) begin
      m_armed = 0; m_evt = 0; m_ovf = 0; m_valid = 0;
      return;
    end
    if (p) begin
      m_evt = (m_evt + 1) % (1 << EVT_W);
      if (m_armed) begin
        cap = (m_cyc - m_last > T_MAX) ? T_MAX : int'(m_cyc - m_last);
        cap_ok = 1;
      end
      m_last  = m_cyc;
      m_armed = 1;
    end else if (m_armed && (m_cyc - m_last >= T_MAX)) begin
      m_ovf = 1;
    end
    if (cap_ok) begin
      if (!m_valid || r) begin
        m_interval = cap;
        m_valid = 1;
      end else begin
        m_drop = 1;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_model();
    check("interval", int'(INTERVAL), m_interval);
    check("int_valid", int'(INT_VALID), int'(m_valid));
    check("evt_cnt", int'(EVT_CNT), m_evt);
    check("ovf", int'(OVF), int'(m_ovf));
    check("drop", int'(DROP), int'(m_drop));
  endtask

  task automatic tick(input logic p, input logic c, input logic r);
    bit was_valid;
    was_valid = m_valid;
    EDGE_PULSE = p;
    CLR = c;
    INT_READY = r;
    @(posedge CLK);
    model_edge(p, c, r);
    #1;
    compare_model();
    if (m_valid && (!was_valid || r) && p && !c)
      $display("capture: interval=%0d evt=%0d ovf=%0d", INTERVAL, EVT_CNT, OVF);
  endtask

  initial begin
    model_reset();

    // Power-on reset held for three cycles
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_interval", int'(INTERVAL), 0);
    check("rst_valid", int'(INT_VALID), 0);
    check("rst_evt", int'(EVT_CNT), 0);
    check("rst_ovf", int'(OVF), 0);
    check("rst_drop", int'(DROP), 0);

    // Back-pressure, drop, release, then CLR coinciding with a pulse
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 2, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 3, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4, 1'b1, 3, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4, 1'b0, 3, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4, 1'b0, 3, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 4, 1'b0, 1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 4, 1'b0, 1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 2, 1'b1, 2, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 2, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].p, vecs[i].c, vecs[i].r);
      $display("vec %0d: p=%0b c=%0b r=%0b -> interval=%0d valid=%0b evt=%0d drop=%0b ovf=%0b",
               i, vecs[i].p, vecs[i].c, vecs[i].r, INTERVAL, INT_VALID, EVT_CNT, DROP, OVF);
      check("vec_interval", int'(INTERVAL), vecs[i].e_interval);
      check("vec_valid", int'(INT_VALID), int'(vecs[i].e_valid));
      check("vec_evt", int'(EVT_CNT), vecs[i].e_evt);
      check("vec_drop", int'(DROP), int'(vecs[i].e_drop));
      check("vec_ovf", int'(OVF), int'(vecs[i].e_ovf));
    end

    // Regular pulses six cycles apart with a ready consumer
    tick(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (k > 0) begin
        check("per6_interval", int'(INTERVAL), 6);
        check("per6_valid", int'(INT_VALID), 1);
      end
      for (int j = 0; j < 5; j++) tick(1'b0, 1'b0, 1'b1);
    end
    check("per6_evt", int'(EVT_CNT), 4);

    // Saturation: 20-cycle gap then a 5-cycle gap
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    for (int j = 1; j < 20; j++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (j == 14) check("ovf_before", int'(OVF), 0);
      if (j == 15) check("ovf_at15", int'(OVF), 1);
    end
    tick(1'b1, 1'b0, 1'b1);
    check("sat_interval", int'(INTERVAL), T_MAX);
    for (int j = 1; j < 5; j++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("gap5_interval", int'(INTERVAL), 5);
    check("gap5_ovf", int'(OVF), 1);

    // Three back-to-back pulses from IDLE
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("b2b_interval1", int'(INTERVAL), 1);
    tick(1'b1, 1'b0, 1'b1);
    check("b2b_interval2", int'(INTERVAL), 1);
    check("b2b_evt", int'(EVT_CNT), 3);

    // Event counter wraps after 256 pulses
    tick(1'b0, 1'b1, 1'b1);
    for (int j = 0; j < 256; j++) tick(1'b1, 1'b0, 1'b1);
    check("evt_wrap", int'(EVT_CNT), 0);

    // Randomized traffic against the model
    for (int j = 0; j < 3000; j++) begin
      tick(logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 63) == 0),
           logic'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-measurement, then the first pulse only re-arms
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    compare_model();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    check("rearm_valid", int'(INT_VALID), 0);
    check("rearm_evt", int'(EVT_CNT), 1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check("rearm_interval", int'(INTERVAL), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_interval_meter.md
Name: edge_interval_meter

Overview:
- Consumer stage directly downstream of the rising-edge detector.
- Takes the detector's single-cycle low-to-high pulse and counts the events.
- Measures the CLK-cycle interval between successive pulses.
- Presents each measured interval through a one-entry valid/ready output register, with saturation, overflow and drop flags.

Parameters:
CNT_W, 16, width of interval timer and INTERVAL output
EVT_W, 8, width of event counter EVT_CNT

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
EDGE_PULSE  input  1  edge-event strobe from the edge detector; each high cycle is one event
CLR  input  1  synchronous clear of all measurement state
INT_READY  input  1  downstream accepts INTERVAL when INT_VALID=1
INTERVAL  output  CNT_W  measured cycles between the last two events
INT_VALID  output  1  INTERVAL holds an unconsumed result
EVT_CNT  output  EVT_W  events seen since reset/clear, modulo 2^EVT_W
OVF  output  1  sticky: timer saturated at least once
DROP  output  1  one-cycle strobe: a capture was discarded because the output register was full

Behaviour:
- Interface: one clock CLK; RST is asynchronous and active-high. Asserting RST immediately forces state IDLE and clears the internal timer. It also clears INTERVAL=0, INT_VALID=0, EVT_CNT=0, OVF=0 and DROP=0. Deassertion needs no synchronisation inside this block.
- States: IDLE (no reference event yet), MEASURE (timer running since last event).
- IDLE:
  - Timer = 0.
  - On EDGE_PULSE: timer <= 1, go to MEASURE, no capture.
- MEASURE, no pulse: timer <= timer+1, saturating at 2^CNT_W-1. On the first cycle timer would exceed max, OVF <= 1 (sticky).
- MEASURE, pulse:
  - Capture value = current timer, which equals the number of CLK edges since the previous event. Pulses at edges t0 and t1 give capture t1-t0. A saturated timer captures all-ones.
  - Then timer <= 1 and stay in MEASURE.
- Output register, evaluated at the capturing edge:
  - If INT_VALID=0, or INT_VALID=1 with INT_READY=1: INTERVAL <= capture, INT_VALID <= 1.
  - If INT_VALID=1 with INT_READY=0: the capture is discarded, INTERVAL is unchanged, and DROP=1 for exactly one cycle.
  - Without a capture, INT_READY=1 with INT_VALID=1 clears INT_VALID next cycle. INTERVAL keeps its last value.
  - INT_READY while INT_VALID=0 has no effect.
- Latency: INTERVAL/INT_VALID are visible the cycle after the edge that sampled the second pulse.
- EVT_CNT increments on every sampled EDGE_PULSE, including the first in IDLE. It wraps 2^EVT_W-1 -> 0 with no flag.
- EDGE_PULSE high for N consecutive cycles = N events. Each one after the first captures interval 1.
- CLR (synchronous, highest priority after RST):
  - Next state IDLE, timer 0, EVT_CNT 0, OVF 0, INT_VALID 0, DROP 0.
  - A pulse coinciding with CLR is ignored: not counted, no capture.
  - INTERVAL data is left unchanged.
- RST mid-measurement discards any in-progress interval. The first pulse after release only re-arms, as in IDLE.
- DROP is 0 in every cycle without a discarded capture.

Test Plan:
1. RST=1 for 3 cycles, then 0, EDGE_PULSE=0 -> all outputs 0; state IDLE; EVT_CNT=0.
2. Pulses at edges 10, 16, 22, 28 (detector fed an input toggling every 3 cycles), INT_READY=1 -> EVT_CNT=4; three results INTERVAL=6, each INT_VALID for one cycle after edges 16, 22, 28; DROP never 1.
3. CNT_W=4; pulses 20 cycles apart -> OVF=1 from the 15th cycle after the first pulse; INTERVAL=15; a later 5-cycle gap gives INTERVAL=5 and OVF stays 1.
4. INT_READY=0; pulses at edges 0, 4, 9 -> INTERVAL=4, INT_VALID=1 holds; DROP=1 for the one cycle after edge 9; raising INT_READY then clears INT_VALID next cycle with INTERVAL still 4.
5. EDGE_PULSE high for 3 consecutive cycles from IDLE -> EVT_CNT=3; two captures of INTERVAL=1 (INT_READY=1).
6. CLR and EDGE_PULSE together during MEASURE, EVT_CNT=5 -> EVT_CNT=0, INT_VALID=0, OVF=0; next pulse only re-arms (EVT_CNT=1, no capture). Separately, 256 pulses with EVT_W=8 -> EVT_CNT wraps to 0.
